instruction_packer: RTL and testbench
=====================================

INSTRUCTION_PACKER -- requirements
Module: instruction_packer

Interface
REQ-001 SHALL provide parameter ADDR_W, default 8, width of the instruction-memory write address.
REQ-002 SHALL provide parameter DEPTH, default 4, number of packed-word buffer entries (power of two, >= 2).
REQ-003 SHALL provide port clk input 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_n input 1, reset, synchronous, active-low.
REQ-005 SHALL provide port start input 1, a one-cycle pulse that restarts a load session.
REQ-006 SHALL provide port in_valid input 1, field set present.
REQ-007 SHALL provide port in_ready output 1, field set accepted this cycle when in_valid is also 1.
REQ-008 SHALL provide ports op input [0:5], rs1 input [0:1], rs2 input [0:1], rd input [0:1] and immediate input [0:11], the instruction fields.
REQ-009 SHALL provide port mem_we output 1, write request to instruction memory.
REQ-010 SHALL provide port mem_ready input 1, memory accepts the write this cycle.
REQ-011 SHALL provide port mem_addr output [0:ADDR_W-1], the write address.
REQ-012 SHALL provide port mem_wdata output [0:23], the packed instruction word.
REQ-013 SHALL provide port count output [0:$clog2(DEPTH)], the buffer occupancy.
REQ-014 SHALL provide port done output 1, sticky flag meaning the memory is full.

Function
REQ-015 SHALL pack each word as bits 0:5 = op, 6:7 = rs1, 8:9 = rs2, 10:11 = rd and 12:23 = immediate, with bit 0 as the MSB.
REQ-016 SHALL accept a field set only on in_valid && in_ready, and SHALL hold in_ready = !full && !done.
REQ-017 SHALL buffer accepted words in a FIFO of DEPTH entries and present the head word on mem_wdata.
REQ-018 SHALL give one-cycle latency: a word accepted at edge N drives mem_we=1 with that word from cycle N+1 when the buffer was empty.
REQ-019 SHALL drive mem_we = (count != 0) && !done.
REQ-020 SHALL complete a write on mem_we && mem_ready, which pops the head and increments mem_addr by 1.
REQ-021 SHALL hold mem_we, mem_addr and mem_wdata stable while mem_we=1 and mem_ready=0.
REQ-022 SHALL leave count unchanged on a simultaneous push and pop.
REQ-023 SHALL deassert in_ready when full, even if a pop completes in the same cycle.
REQ-024 SHALL, on a completed write to address 2^ADDR_W-1, wrap mem_addr to 0 and set done.
REQ-025 SHALL, while done=1, force mem_we=0 and in_ready=0 and retain the buffer contents.
REQ-026 SHALL, on start=1, clear the FIFO, count, mem_addr and done at the next edge, taking priority over any push or pop in that cycle.
REQ-027 SHALL ignore mem_ready while mem_we=0.

Reset
REQ-028 SHALL, when rst_n=0 at a rising edge, set count=0, mem_addr=0, done=0 and the checksum to 0, giving mem_we=0 and in_ready=1.
REQ-029 SHALL give reset priority over start, push and pop; a reset during an active load discards all buffered words.

Configuration
REQ-030 SHALL, when INSTR_PACKER_CKSUM_EN is defined, add port cksum output [0:23], a register updated to cksum XOR mem_wdata on each completed write and cleared by reset and by start.
REQ-031 SHALL, when INSTR_PACKER_CKSUM_EN is undefined, omit the cksum port and all checksum logic, with no other behavioural change.

Verification
REQ-032 The bench SHALL cover: op=6'h2A, rs1=1, rs2=2, rd=3, imm=12'hABC with mem_ready=1 -> mem_wdata=24'hA9BABC, mem_addr=0 on the next cycle, then mem_addr=1.
REQ-033 The bench SHALL cover: mem_ready=0 while 5 sets are offered -> count reaches 4, in_ready=0, the 5th set is held until a pop, and all words are written in order.
REQ-034 The bench SHALL cover: ADDR_W=2 with 4 words written -> done=1 after the 4th write, mem_addr=0, mem_we=0, in_ready=0; then start -> done=0 and in_ready=1.
REQ-035 The bench SHALL cover: push and pop together at count=2 -> count stays 2 and the data order is preserved.
REQ-036 The bench SHALL cover: rst_n=0 asserted mid-stall with count=3 -> next cycle count=0, mem_we=0, mem_addr=0.
REQ-037 The bench SHALL cover, with INSTR_PACKER_CKSUM_EN defined: write 24'h000001 then 24'h000003 -> cksum=24'h000002.

Source files
------------

// File: rtl/instruction_packer.sv
// Packs instruction fields into 24-bit words, buffers them in a small FIFO and streams them to instruction memory.
// Optional running XOR checksum of written words: define INSTR_PACKER_CKSUM_EN.
module instruction_packer #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [0:5]               op,
   input  logic [0:1]               rs1,
   input  logic [0:1]               rs2,
   input  logic [0:1]               rd,
   input  logic [0:11]              immediate,
   output logic                     mem_we,
   input  logic                     mem_ready,
   output logic [0:ADDR_W-1]        mem_addr,
   output logic [0:23]              mem_wdata,
   output logic [0:$clog2(DEPTH)]   count,
   output logic                     done
`ifdef INSTR_PACKER_CKSUM_EN
   ,
   output logic [0:23]              cksum
`endif
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [0:23]       word_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count_q;
   logic [ADDR_W-1:0] addr_q;
   logic              done_q;
   logic              full;
   logic              push;
   logic              pop;

   // Field order puts op in the most significant bits (bit 0 of the word).
   function automatic logic [0:23] pack_word(input logic [0:5]  f_op,
                                             input logic [0:1]  f_rs1,
                                             input logic [0:1]  f_rs2,
                                             input logic [0:1]  f_rd,
                                             input logic [0:11] f_imm);
      return {f_op, f_rs1, f_rs2, f_rd, f_imm};
   endfunction

   assign full      = (count_q == (PTR_W+1)'(DEPTH));
   assign in_ready  = !full && !done_q;
   assign mem_we    = (count_q != '0) && !done_q;
   assign push      = in_valid && in_ready;
   assign pop       = mem_we && mem_ready;
   assign mem_wdata = word_q[rd_ptr];
   assign mem_addr  = addr_q;
   assign count     = count_q;
   assign done      = done_q;

   // Storage carries no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         word_q[wr_ptr] <= pack_word(op, rs1, rs2, rd, immediate);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || start) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         addr_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            addr_q <= addr_q + ADDR_W'(1);
            // Writing the last address fills the memory; the address wraps to 0.
            if (&addr_q) begin
               done_q <= 1'b1;
            end
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

`ifdef INSTR_PACKER_CKSUM_EN
   logic [0:23] cksum_q;

   always_ff @(posedge clk) begin
      if (!rst_n || start) begin
         cksum_q <= '0;
      end else if (pop) begin
         cksum_q <= cksum_q ^ mem_wdata;
      end
   end

   assign cksum = cksum_q;
`endif

endmodule

// File: tb/tb_instruction_packer.sv
// Bench for instruction_packer: directed scenarios plus a random run against a queue-based reference model.
// A second instance with ADDR_W=2 exercises the memory-full behaviour.
module tb_instruction_packer;

   logic        clk = 1'b0;
   logic        rst_n, start, in_valid, mem_ready;
   logic [0:5]  op;
   logic [0:1]  rs1, rs2, rd;
   logic [0:11] imm;

   logic        in_ready, mem_we, done;
   logic [0:7]  mem_addr;
   logic [0:23] mem_wdata;
   logic [0:2]  count;

   logic        s_in_ready, s_mem_we, s_done;
   logic [0:1]  s_mem_addr;
   logic [0:23] s_mem_wdata;
   logic [0:2]  s_count;
`ifdef INSTR_PACKER_CKSUM_EN
   logic [0:23] cksum, s_cksum;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   instruction_packer #(.ADDR_W(8), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .rs1(rs1), .rs2(rs2), .rd(rd), .immediate(imm),
      .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .count(count), .done(done)
`ifdef INSTR_PACKER_CKSUM_EN
      , .cksum(cksum)
`endif
   );

   instruction_packer #(.ADDR_W(2), .DEPTH(4)) dut_small (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
      .op(op), .rs1(rs1), .rs2(rs2), .rd(rd), .immediate(imm),
      .mem_we(s_mem_we), .mem_ready(mem_ready), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
      .count(s_count), .done(s_done)
`ifdef INSTR_PACKER_CKSUM_EN
      , .cksum(s_cksum)
`endif
   );

   // Reference model of the default instance: a word queue, a write address and a sticky full flag.
   logic [23:0] mq[$];
   int          m_addr = 0;
   bit          m_done = 1'b0;
   logic [23:0] m_ck   = '0;
   bit          chk_en = 1'b0;
   bit          last_acc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rand_fields();
      op  = 6'($urandom);
      rs1 = 2'($urandom);
      rs2 = 2'($urandom);
      rd  = 2'($urandom);
      imm = 12'($urandom);
   endtask

   // Compare the default instance to the model, advance the model, then move to the next falling edge.
   task automatic tick();
      bit          m_rdy, m_we;
      logic [23:0] w;
      m_rdy = (mq.size() < 4) && !m_done;
      m_we  = (mq.size() != 0) && !m_done;
      if (chk_en) begin
         chk("in_ready", 32'(in_ready), 32'(m_rdy));
         chk("mem_we", 32'(mem_we), 32'(m_we));
         chk("count", 32'(count), 32'(mq.size()));
         chk("mem_addr", 32'(mem_addr), 32'(m_addr));
         chk("done", 32'(done), 32'(m_done));
         if (m_we) chk("mem_wdata", 32'(mem_wdata), 32'(mq[0]));
`ifdef INSTR_PACKER_CKSUM_EN
         chk("cksum", 32'(cksum), 32'(m_ck));
`endif
      end
      last_acc = rst_n && !start && in_valid && m_rdy;
      if (!rst_n || start) begin
         mq.delete();
         m_addr = 0;
         m_done = 1'b0;
         m_ck   = '0;
      end else begin
         if (m_we && mem_ready) begin
            m_ck = m_ck ^ mq[0];
            void'(mq.pop_front());
            if (m_addr == 255) begin
               m_addr = 0;
               m_done = 1'b1;
            end else begin
               m_addr++;
            end
         end
         if (in_valid && m_rdy) begin
            w = {op, rs1, rs2, rd, imm};
            mq.push_back(w);
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      mem_ready = 1'b1;
      for (int k = 0; k < 20 && mq.size() != 0; k++) tick();
      chk("drain_count", 32'(count), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
      op = '0; rs1 = '0; rs2 = '0; rd = '0; imm = '0;
      @(negedge clk);
      tick();
      chk_en = 1'b1;
      rst_n  = 1'b1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_done", 32'(done), 32'd0);

      // Single word, known packing, one-cycle latency.
      op = 6'h2A; rs1 = 2'd1; rs2 = 2'd2; rd = 2'd3; imm = 12'hABC;
      in_valid = 1'b1; mem_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("pack_we", 32'(mem_we), 32'd1);
      chk("pack_wdata", 32'(mem_wdata), 32'h00A9BABC);
      chk("pack_addr0", 32'(mem_addr), 32'd0);
      tick();
      chk("pack_addr1", 32'(mem_addr), 32'd1);
      chk("pack_count", 32'(count), 32'd0);

      // Memory stalled while five sets are offered.
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rand_fields();
         in_valid = 1'b1;
         tick();
      end
      rand_fields();
      for (int i = 0; i < 3; i++) tick();
      chk("full_count", 32'(count), 32'd4);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      mem_ready = 1'b1;
      tick();
      chk("full_pop_no_push", 32'(count), 32'd3);
      for (int k = 0; k < 10; k++) begin
         tick();
         if (last_acc) break;
      end
      chk("fifth_accepted", 32'(last_acc), 32'd1);
      drain();

      // Simultaneous push and pop at occupancy two.
      mem_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rand_fields();
         in_valid = 1'b1;
         tick();
      end
      rand_fields();
      mem_ready = 1'b1;
      tick();
      chk("pushpop_count", 32'(count), 32'd2);
      drain();

      // Reset in the middle of a stall.
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rand_fields();
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      tick();
      chk("stall_count", 32'(count), 32'd3);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("midrst_count", 32'(count), 32'd0);
      chk("midrst_we", 32'(mem_we), 32'd0);
      chk("midrst_addr", 32'(mem_addr), 32'd0);

`ifdef INSTR_PACKER_CKSUM_EN
      op = '0; rs1 = '0; rs2 = '0; rd = '0;
      imm = 12'h001; in_valid = 1'b1; mem_ready = 1'b1;
      tick();
      imm = 12'h003;
      tick();
      drain();
      chk("cksum_1_3", 32'(cksum), 32'h00000002);
`endif

      // Fill the four-entry address space of the small instance.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rand_fields();
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      for (int k = 0; k < 10 && !s_done; k++) tick();
      chk("small_done", 32'(s_done), 32'd1);
      chk("small_addr_wrap", 32'(s_mem_addr), 32'd0);
      chk("small_we", 32'(s_mem_we), 32'd0);
      chk("small_in_ready", 32'(s_in_ready), 32'd0);
      in_valid = 1'b1;
      tick();
      chk("small_done_sticky", 32'(s_done), 32'd1);
      chk("small_no_push", 32'(s_count), 32'd0);
      in_valid = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("small_start_done", 32'(s_done), 32'd0);
      chk("small_start_ready", 32'(s_in_ready), 32'd1);
      drain();

      // Random traffic against the model, long enough to wrap the default address space.
      for (int c = 0; c < 1500; c++) begin
         rand_fields();
         in_valid  = ($urandom_range(0, 3) != 0);
         mem_ready = ($urandom_range(0, 2) != 0);
         start     = ($urandom_range(0, 399) == 0);
         rst_n     = ($urandom_range(0, 599) != 0);
         tick();
      end
      start = 1'b0; rst_n = 1'b1; in_valid = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
